pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/pipe_slot.sv | 53 +++++
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for pipeline stage registers. Holds the
//               EX/MEM control struct, field widths and bit offsets, and the
//               no-op control constant loaded on reset, flush and bubble.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // EX/MEM control field: one bit per control line, MSB first
    localparam int EXMEM_CTRL_W    = 6;
    localparam int REGWRITE_BIT    = 5;
    localparam int MEMREAD_BIT     = 4;
    localparam int MEMWRITE_BIT    = 3;
    localparam int MEMTOREG_BIT    = 2;
    localparam int SAVEPC_BIT      = 1;
    localparam int HALT_BIT        = 0;

    // EX/MEM data field layout: {alu, store, pc_plus4, funct3, rd}
    localparam int EXMEM_RD_W      = 5;
    localparam int EXMEM_FUNCT3_W  = 3;
    localparam int EXMEM_PC_W      = 16;
    localparam int EXMEM_STORE_W   = 32;
    localparam int EXMEM_ALU_W     = 32;
    localparam int EXMEM_RD_LSB    = 0;
    localparam int EXMEM_FUNCT3_LSB = EXMEM_RD_LSB + EXMEM_RD_W;
    localparam int EXMEM_PC_LSB    = EXMEM_FUNCT3_LSB + EXMEM_FUNCT3_W;
    localparam int EXMEM_STORE_LSB = EXMEM_PC_LSB + EXMEM_PC_W;
    localparam int EXMEM_ALU_LSB   = EXMEM_STORE_LSB + EXMEM_STORE_W;
    localparam int EXMEM_DATA_W    = EXMEM_ALU_LSB + EXMEM_ALU_W;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic save_pc;
        logic halt;
    } exmem_ctrl_t;

    // All control lines deasserted: downstream treats the slot as a no-op
    localparam exmem_ctrl_t CTRL_NOP = '0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One pipeline entry: a valid bit plus control/data registers.
//               Clear invalidates the entry and returns control to CTRL_RST
//               (data is kept, it is don't-care while invalid). Load captures
//               a new entry. Clear wins over load.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = 6,
    parameter int                DATA_W   = 88,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Entry register: control is forced to CTRL_RST whenever the entry is invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RST;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= CTRL_RST;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Reusable pipeline stage register carrying a control and a
//               data vector with valid/ready handshaking, synchronous flush
//               and bubble insertion (out_ctrl = CTRL_RST while invalid).
//               Build option PIPE_STAGE_SKID_EN adds a skid slot so that
//               in_ready comes straight from a flop; without it the stage is
//               a single slot with in_ready = !out_valid | out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = 6,
    parameter int                DATA_W   = 88,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic w_main_valid;
    logic w_main_load;
    logic w_main_clear;
    logic w_accept;
    logic w_retire;

    assign w_accept  = in_valid & in_ready;
    assign w_retire  = w_main_valid & out_ready;
    assign out_valid = w_main_valid;

`ifdef PIPE_STAGE_SKID_EN

    logic              w_skid_valid;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_main_from_skid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_main_ld_ctrl;
    logic [DATA_W-1:0] w_main_ld_data;

    // Registered ready: the skid slot being empty guarantees room for one more
    assign in_ready  = !w_skid_valid;
    assign occupancy = 2'(w_main_valid) + 2'(w_skid_valid);

    // Slot steering: flush kills both; skid refills main before any new entry
    always_comb begin
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else if (w_retire && w_skid_valid) begin
            // in_ready is low here, so no new entry can collide with the move
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
        end else if (w_accept && (!w_main_valid || w_retire)) begin
            w_main_load = 1'b1;
        end else if (w_accept) begin
            w_skid_load = 1'b1;
        end else if (w_retire) begin
            w_main_clear = 1'b1;
        end
    end

    assign w_main_ld_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_ld_data = w_main_from_skid ? w_skid_data : in_data;

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_RST (CTRL_RST)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_skid_clear),
        .i_load  (w_skid_load),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

`else

    logic [CTRL_W-1:0] w_main_ld_ctrl;
    logic [DATA_W-1:0] w_main_ld_data;

    // Single slot: room exists when empty or when the head leaves this cycle
    assign in_ready       = !w_main_valid | out_ready;
    assign occupancy      = {1'b0, w_main_valid};
    assign w_main_ld_ctrl = in_ctrl;
    assign w_main_ld_data = in_data;

    // Slot steering: flush wins; a new entry replaces a retiring one in place
    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        if (flush) begin
            w_main_clear = 1'b1;
        end else if (w_accept) begin
            w_main_load = 1'b1;
        end else if (w_retire) begin
            w_main_clear = 1'b1;
        end
    end

`endif

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_RST (CTRL_RST)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_main_clear),
        .i_load  (w_main_load),
        .i_ctrl  (w_main_ld_ctrl),
        .i_data  (w_main_ld_data),
        .o_valid (w_main_valid),
        .o_ctrl  (out_ctrl),
        .o_data  (out_data)
    );

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg. A queue holds the
//               entries the stage should currently contain; every cycle the
//               DUT outputs are compared with the queue head and size.
//               Build option PIPE_STAGE_SKID_EN selects the two-entry model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int CTRL_W = 6;
    localparam int DATA_W = 88;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    ent_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_RST ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected in_ready from the model state before the edge
    function automatic logic exp_ready(input logic ordy);
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || ordy;
`endif
    endfunction

    // One cycle: drive after the edge, compare on the falling edge, update model
    task automatic step(input logic iv, input logic [CTRL_W-1:0] ic,
                        input logic [DATA_W-1:0] id, input logic ordy, input logic fl);
        logic rdy;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        rdy = exp_ready(ordy);
        chk("in_ready", 128'(in_ready), 128'(rdy));
        chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
        chk("occupancy", 128'(occupancy), 128'(q.size()));
        if (q.size() != 0) begin
            chk("out_ctrl", 128'(out_ctrl), 128'(q[0].c));
            chk("out_data", 128'(out_data), 128'(q[0].d));
        end else begin
            chk("out_ctrl_bubble", 128'(out_ctrl), 128'(0));
        end
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (iv && rdy) q.push_back('{c: ic, d: id});
        end
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state, no clock edge yet
        #2;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Streaming 0x01..0x10 with out_ready held high
        for (int i = 1; i <= 16; i++) step(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Stall: hold 0xAA while 0xBB is offered, then release
        step(1'b1, 6'h21, DATA_W'('hAA), 1'b1, 1'b0);
        step(1'b1, 6'h22, DATA_W'('hBB), 1'b0, 1'b0);
        step(1'b1, 6'h22, DATA_W'('hBB), 1'b0, 1'b0);
        step(1'b1, 6'h22, DATA_W'('hBB), 1'b0, 1'b0);
        step(1'b1, 6'h22, DATA_W'('hBB), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush priority with an entry offered in the flush cycle
        step(1'b1, 6'h11, DATA_W'('h11), 1'b0, 1'b0);
        step(1'b1, 6'h12, DATA_W'('h22), 1'b0, 1'b0);
        step(1'b1, 6'h3F, DATA_W'('hCC), 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush while empty, with an offered entry that must be dropped
        step(1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b1, 6'h15, DATA_W'('hDD), 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Bubble after an all-ones control entry retires
        step(1'b1, 6'h3F, DATA_W'('h55), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Mixed traffic with random back-pressure and occasional flush
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) != 0), CTRL_W'($urandom),
                 DATA_W'({$urandom, $urandom, $urandom}),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-stream with one entry held
        step(1'b1, 6'h2A, DATA_W'('h77), 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("async_rst_out_valid", 128'(out_valid), 128'(0));
        chk("async_rst_occupancy", 128'(occupancy), 128'(0));
        chk("async_rst_out_ctrl", 128'(out_ctrl), 128'(0));
        chk("async_rst_out_data", 128'(out_data), 128'(0));
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, 6'h01, DATA_W'('h99), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
